// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state encodings, default frame length and helpers for the SPI master
package spi_master_pkg;

    localparam int SPI_DEFAULT_DATA_LENGTH = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // A divider of zero would stall the half-period counter, so it runs as one.
    function automatic logic [7:0] half_period(input logic [7:0] clk_div);
        return (clk_div == 8'd0) ? 8'd1 : clk_div;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period down-counter emitting a one-cycle tick every H clk cycles
module spi_clk_gen (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] half,
    output logic       tick
);

    logic [7:0] cnt;

    assign tick = run && (cnt == 8'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 8'd0;
        end else if (load || tick) begin
            cnt <= half;
        end else if (run && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master with configurable polarity, phase, divider and frame length
module spi_master
    import spi_master_pkg::*;
#(
    parameter int data_length = SPI_DEFAULT_DATA_LENGTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic [7:0]             clk_div,
    input  logic [data_length-1:0] tx,
    output logic [data_length-1:0] rx,
    output logic                   busy,
    output logic                   done,
    output logic                   sclk,
    output logic                   ss_n,
    output logic                   mosi,
    input  logic                   miso
);

    localparam int MSB = data_length - 1;
    localparam int EW  = $clog2(2 * data_length + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * data_length);

    logic [2:0]             state;
    logic                   cpol_q;
    logic                   cpha_q;
    logic [7:0]             h_q;
    logic [EW-1:0]          edge_cnt;
    logic [data_length-1:0] tx_sr;
    logic [data_length-1:0] rx_sr;

    logic       start;
    logic       tick;
    logic [7:0] h_live;
    logic [7:0] h_sel;
    logic       edge_leading;
    logic       edge_final;
    logic       sample_now;
    logic       shift_now;

    assign h_live = half_period(clk_div);
    assign start  = (state == ST_IDLE) && enable;
    // The counter is loaded in the accept cycle, before h_q holds the latched value.
    assign h_sel  = (state == ST_IDLE) ? h_live : h_q;

    // Describes the sclk edge about to be produced: number edge_cnt+1.
    assign edge_leading = ~edge_cnt[0];
    assign edge_final   = (edge_cnt == (LAST_EDGE - EW'(1)));
    assign sample_now   = edge_leading ^ cpha_q;
    assign shift_now    = cpha_q ? edge_leading : (~edge_leading && ~edge_final);

    spi_clk_gen u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (state != ST_IDLE),
        .load    (start),
        .half    (h_sel),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            h_q      <= 8'd0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ss_n <= 1'b1;
                    sclk <= cpol;
                    mosi <= 1'b0;
                    busy <= 1'b0;
                    if (enable) begin
                        state    <= ST_LEAD;
                        busy     <= 1'b1;
                        ss_n     <= 1'b0;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        h_q      <= h_live;
                        tx_sr    <= tx;
                        rx_sr    <= '0;
                        edge_cnt <= '0;
                        mosi     <= cpha ? 1'b0 : tx[MSB];
                    end
                end
                ST_LEAD, ST_XFER: begin
                    if (tick) begin
                        if ((state == ST_XFER) && (edge_cnt == LAST_EDGE)) begin
                            state <= ST_TRAIL;
                            sclk  <= cpol_q;
                        end else begin
                            state    <= ST_XFER;
                            sclk     <= ~sclk;
                            edge_cnt <= edge_cnt + EW'(1);
                            if (sample_now) begin
                                rx_sr <= {rx_sr[data_length-2:0], miso};
                            end
                            if (shift_now) begin
                                mosi  <= cpha_q ? tx_sr[MSB] : tx_sr[MSB-1];
                                tx_sr <= {tx_sr[data_length-2:0], 1'b0};
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        state <= ST_GAP;
                        ss_n  <= 1'b1;
                        sclk  <= cpol_q;
                        mosi  <= 1'b0;
                        rx    <= rx_sr;
                        done  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with loopback and behavioural slave
module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [7:0]  clk_div = 8'd2;
    logic [15:0] tx = 16'h0000;
    logic [15:0] rx;
    logic        busy, done, sclk, ss_n, mosi, miso;

    logic        loopback = 1'b1;
    logic        s_miso = 1'b0;
    logic [15:0] s_tx = 16'h0000;
    logic [15:0] s_sr = 16'h0000;
    logic [15:0] s_rx = 16'h0000;

    assign miso = loopback ? mosi : s_miso;

    always #5 clk = ~clk;

    spi_master #(.data_length(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .cpol    (cpol),
        .cpha    (cpha),
        .clk_div (clk_div),
        .tx      (tx),
        .rx      (rx),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural slave using the same mode as the master's live cpol/cpha inputs.
    always @(negedge ss_n) begin
        s_sr   = s_tx;
        s_miso = s_tx[15];
    end

    always @(sclk) begin
        if (!loopback && !ss_n) begin
            if ((sclk != cpol) ^ cpha) begin
                s_rx = {s_rx[14:0], mosi};
            end else if (cpha) begin
                s_miso = s_sr[15];
                s_sr   = {s_sr[14:0], 1'b0};
            end else begin
                s_sr   = {s_sr[14:0], 1'b0};
                s_miso = s_sr[15];
            end
        end
    end

    // Scoreboard monitor and waveform measurements.
    logic [15:0] exp_q[$];
    logic [15:0] exp_rx;
    int done_total = 0;
    int ss_low = 0;
    int edges = 0;
    int hi_run = 0;
    int last_hi_run = 0;
    logic prev_sclk = 1'b0;
    logic prev_ss = 1'b1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_total++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_rx = exp_q.pop_front();
                check("rx_word", rx, exp_rx);
            end
        end
        if (!ss_n) ss_low++;
        if (!ss_n && (sclk !== prev_sclk)) edges++;
        if (ss_n) begin
            hi_run++;
        end else begin
            if (prev_ss) last_hi_run = hi_run;
            hi_run = 0;
        end
        prev_sclk = sclk;
        prev_ss   = ss_n;
    end

    task automatic start_frame(input logic p, input logic ph, input logic [7:0] d, input logic [15:0] t);
        @(negedge clk);
        cpol = p; cpha = ph; clk_div = d; tx = t;
        @(negedge clk);
        ss_low = 0; edges = 0;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int base, input int target);
        int waited;
        waited = 0;
        while ((done_total - base) < target && waited < 3000) begin
            @(negedge clk); #1;
            waited++;
        end
        if ((done_total - base) < target) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (busy !== 1'b0 && waited < 3000) begin
            @(negedge clk); #1;
            waited++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_edges(input int n);
        int waited;
        waited = 0;
        while (edges < n && waited < 3000) begin
            @(negedge clk); #1;
            waited++;
        end
        if (edges < n) check("edge_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] mtx;
        mtx = 16'h1234;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_ss_n", ss_n, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx", rx, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle sclk follows live cpol
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sclk_cpol1", sclk, 1'b1);
        cpol = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_sclk_cpol0", sclk, 1'b0);

        // Mode 0 loopback, clk_div=2
        base = done_total;
        exp_q.push_back(16'hA5C3);
        start_frame(1'b0, 1'b0, 8'd2, 16'hA5C3);
        check("busy_after_start", busy, 1'b1);
        wait_done(base, 1);
        check("m0_edges", edges, 32);
        check("m0_ss_low", ss_low, 68);
        wait_idle();
        check("m0_done_count", done_total - base, 1);

        // All four modes against the behavioural slave
        loopback = 1'b0;
        s_tx = 16'hBEEF;
        for (int m = 0; m < 4; m++) begin
            base = done_total;
            s_rx = 16'h0000;
            exp_q.push_back(16'hBEEF);
            start_frame(m[1], m[0], 8'd3, mtx);
            wait_done(base, 1);
            check("slave_rx", s_rx, 16'h1234);
            check("mode_edges", edges, 32);
            wait_idle();
        end
        loopback = 1'b1;

        // clk_div=0 behaves like clk_div=1
        exp_q.push_back(16'h3C5A);
        base = done_total;
        start_frame(1'b0, 1'b1, 8'd0, 16'h3C5A);
        wait_done(base, 1);
        check("div0_ss_low", ss_low, 34);
        check("div0_edges", edges, 32);
        wait_idle();
        exp_q.push_back(16'hC35A);
        base = done_total;
        start_frame(1'b1, 1'b0, 8'd1, 16'hC35A);
        wait_done(base, 1);
        check("div1_ss_low", ss_low, 34);
        wait_idle();

        // enable and tx changes during XFER are ignored
        exp_q.push_back(16'h1357);
        base = done_total;
        start_frame(1'b0, 1'b0, 8'd2, 16'h1357);
        wait_edges(5);
        tx = 16'hFFFF;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_done(base, 1);
        wait_idle();
        repeat (20) @(negedge clk);
        #1;
        check("no_second_frame", done_total - base, 1);
        check("idle_after_ignored", busy, 1'b0);

        // Reset at edge 10 aborts the frame
        base = done_total;
        start_frame(1'b0, 1'b0, 8'd2, 16'hAAAA);
        wait_edges(10);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ss_n", ss_n, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rx", rx, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort_no_done", done_total - base, 0);
        exp_q.push_back(16'h00FF);
        start_frame(1'b0, 1'b0, 8'd2, 16'h00FF);
        wait_done(base, 1);
        wait_idle();

        // enable held high: two back-to-back frames
        base = done_total;
        exp_q.push_back(16'h6B9D);
        exp_q.push_back(16'h6B9D);
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd2; tx = 16'h6B9D;
        enable = 1'b1;
        wait_done(base, 1);
        begin
            int waited;
            waited = 0;
            while (ss_n !== 1'b0 && waited < 100) begin
                @(negedge clk); #1;
                waited++;
            end
            if (ss_n !== 1'b0) check("second_start_timeout", 32'd0, 32'd1);
        end
        enable = 1'b0;
        check("gap_high_cycles", last_hi_run, 3);
        wait_done(base, 2);
        wait_idle();
        repeat (20) @(negedge clk);
        #1;
        check("b2b_done_count", done_total - base, 2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
